// File: rtl/jtag_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_boot_pkg
// Purpose  : Shared command encoding, FSM states and TMS navigation patterns
//            for the JTAG boot sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_boot_pkg;

    typedef enum logic [1:0] {
        CMD_RESET = 2'd0,
        CMD_IR    = 2'd1,
        CMD_DR    = 2'd2,
        CMD_IDLE  = 2'd3
    } jtag_cmd_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RST_SEQ = 3'd1;
    localparam state_t ST_PRE     = 3'd2;
    localparam state_t ST_SHIFT   = 3'd3;
    localparam state_t ST_POST    = 3'd4;
    localparam state_t ST_WAIT    = 3'd5;
    localparam state_t ST_RSP     = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    // TMS patterns are played LSB first, starting from Run-Test/Idle.
    localparam logic [3:0] IR_PRE       = 4'b0011;
    localparam logic [2:0] DR_PRE       = 3'b001;
    localparam logic [1:0] POST_SEQ     = 2'b01;
    localparam int         RESET_CYCLES = 5;

endpackage
`default_nettype wire

// File: rtl/jtag_boot_sequencer_tck_gen.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tck_gen
// Purpose  : TCK divider with one-clk strobes on the edges where TCK rises
//            and falls; idles low and restarts at the start of a low phase.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_term;

    assign w_term   = en && (r_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_stb = w_term & ~r_phase;
    assign fall_stb = w_term & r_phase;
    assign tck      = r_phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_term) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jtag_boot_sequencer
// Purpose  : Plays RESET/IR/DR/IDLE TAP commands, verifies masked readback
//            and releases fetch_enable after a clean boot sequence.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_boot_sequencer
    import jtag_boot_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_exp,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic              cmd_last,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_mismatch,
    output logic              busy,
    output logic              done_o,
    output logic              error_o,
    output logic              fetch_enable_o,
    output logic              tck_o,
    output logic              trstn_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);

    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_exp;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_cap;
    logic              r_last;
    logic [3:0]        r_nav;
    logic [CNT_W-1:0]  r_pre_last;
    logic              r_tms;
    logic              r_tdi;
    logic              r_trstn;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_fetch;

    logic              w_tck_en;
    logic              w_fall;
    logic              w_rise;
    logic              w_accept;
    logic              w_finish;
    logic [LEN_W-1:0]  w_len;
    logic [DATA_W-1:0] w_lenmask;
    jtag_cmd_e         w_type;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (w_tck_en),
        .tck      (tck_o),
        .fall_stb (w_fall),
        .rise_stb (w_rise)
    );

    assign w_tck_en = (r_state == ST_RST_SEQ) || (r_state == ST_PRE) || (r_state == ST_SHIFT)
                   || (r_state == ST_POST) || (r_state == ST_WAIT);
    assign w_type   = jtag_cmd_e'(cmd_type);
    assign w_len    = (cmd_len > LEN_W'(DATA_W - 1)) ? LEN_W'(DATA_W - 1) : cmd_len;

    assign cmd_ready = (r_state == ST_IDLE) && !r_done && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_lenmask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_lenmask[i] = (i <= int'(r_len));
        end
    end

    assign rsp_valid    = (r_state == ST_RSP);
    assign rsp_mismatch = rsp_valid && (|((r_cap ^ r_exp) & r_mask & w_lenmask));

    assign w_finish = ((r_state == ST_RST_SEQ) && w_fall && (r_cnt == CNT_W'(RESET_CYCLES)))
                   || ((r_state == ST_WAIT) && w_fall && (r_cnt == CNT_W'(r_len)))
                   || (r_state == ST_RSP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_data     <= '0;
            r_exp      <= '0;
            r_mask     <= '0;
            r_cap      <= '0;
            r_last     <= 1'b0;
            r_nav      <= '0;
            r_pre_last <= '0;
            r_tms      <= 1'b1;
            r_tdi      <= 1'b0;
            r_trstn    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_fetch    <= 1'b0;
        end else begin
            r_fetch <= r_done & ~r_error;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_len  <= w_len;
                        r_data <= cmd_data;
                        r_exp  <= cmd_exp;
                        r_mask <= cmd_mask;
                        r_last <= cmd_last;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        r_tdi  <= 1'b0;
                        case (w_type)
                            CMD_RESET: begin
                                r_state <= ST_RST_SEQ;
                                r_trstn <= 1'b0;
                                r_tms   <= 1'b1;
                            end
                            CMD_IR: begin
                                r_state    <= ST_PRE;
                                r_nav      <= IR_PRE;
                                r_pre_last <= CNT_W'(3);
                                r_tms      <= IR_PRE[0];
                                r_cap      <= '0;
                            end
                            CMD_DR: begin
                                r_state    <= ST_PRE;
                                r_nav      <= {1'b0, DR_PRE};
                                r_pre_last <= CNT_W'(2);
                                r_tms      <= DR_PRE[0];
                                r_cap      <= '0;
                            end
                            default: begin
                                r_state <= ST_WAIT;
                                r_tms   <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_RST_SEQ: begin
                    if (w_fall) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Final TCK releases TRST and steps into Run-Test/Idle.
                        if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
                            r_trstn <= 1'b1;
                            r_tms   <= 1'b0;
                        end
                    end
                end
                ST_PRE: begin
                    if (w_fall) begin
                        if (r_cnt == r_pre_last) begin
                            r_state <= ST_SHIFT;
                            r_cnt   <= '0;
                            r_tms   <= (r_len == '0);
                            r_tdi   <= r_data[0];
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            r_tms <= r_nav[1];
                            r_nav <= r_nav >> 1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_cap[r_cnt[LEN_W-1:0]] <= tdo_i;
                    end
                    if (w_fall) begin
                        if (r_cnt == CNT_W'(r_len)) begin
                            r_state <= ST_POST;
                            r_cnt   <= '0;
                            r_nav   <= {2'b00, POST_SEQ};
                            r_tms   <= POST_SEQ[0];
                            r_tdi   <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_tdi  <= r_data[1];
                            r_data <= r_data >> 1;
                            r_tms  <= ((r_cnt + CNT_W'(1)) == CNT_W'(r_len));
                        end
                    end
                end
                ST_POST: begin
                    if (w_fall) begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_RSP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            r_tms <= r_nav[1];
                            r_nav <= r_nav >> 1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_fall) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RSP: begin
                    if (rsp_mismatch) begin
                        r_error <= 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_finish) begin
                r_state <= r_last ? ST_DONE : ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= r_last;
            end
        end
    end

    assign rsp_data       = r_cap;
    assign busy           = r_busy;
    assign done_o         = r_done;
    assign error_o        = r_error;
    assign fetch_enable_o = r_fetch;
    assign trstn_o        = r_trstn;
    assign tms_o          = r_tms;
    assign tdi_o          = r_tdi;

endmodule
`default_nettype wire
